demux1to2_buf: RTL and testbench
================================

DEMUX1TO2_BUF -- requirements
Module: demux1to2_buf

Interface
REQ-001 SHALL provide parameter W, default 8, giving the data width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_data, input, W bits: the upstream word.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is presented.
REQ-006 SHALL have port in_sel, input, 1 bit: target output for the word when mode=0 (0 selects y0, 1 selects y1).
REQ-007 SHALL have port mode, input, 1 bit: routing mode (0 = steered by in_sel, 1 = alternating).
REQ-008 SHALL have port in_ready, output, 1 bit: the upstream word is accepted this cycle.
REQ-009 SHALL have ports y0_data (W bits) and y0_valid (1 bit), outputs: output slot 0.
REQ-010 SHALL have port y0_ready, input, 1 bit: the downstream side of slot 0 takes the word.
REQ-011 SHALL have ports y1_data (W bits) and y1_valid (1 bit), outputs, and port y1_ready, input, 1 bit: the same roles for slot 1.
REQ-012 SHALL have ports cnt0 and cnt1, outputs, 8 bits each: completed transfers out of slot 0 and slot 1.

Function
REQ-013 SHALL define target as in_sel when mode=0, and as the internal pointer ptr when mode=1.
REQ-014 SHALL drive in_ready combinationally: in_ready = !yT_valid || yT_ready, where T is the target; in_ready SHALL NOT depend on in_valid.
REQ-015 SHALL accept a word when in_valid && in_ready.
REQ-016 On accept, SHALL load in_data into the target slot data register and set that slot's valid on the next edge, giving 1-cycle latency.
REQ-017 SHALL clear a slot's valid when the slot is valid, its ready is high, and no new word is accepted into it in the same cycle.
REQ-018 When a slot drains and receives a new word in the same cycle, SHALL leave valid high and load the new data, giving a throughput of one word per cycle per slot.
REQ-019 SHALL hold yN_data stable while yN_valid=1 and yN_ready=0.
REQ-020 SHALL keep the two slots independent: a stall on one slot SHALL NOT block words steered to the other slot.
REQ-021 SHALL toggle ptr on each accept while mode=1.
REQ-022 SHALL hold ptr while mode=0; a mode change takes effect for the very next accept.
REQ-023 SHALL increment cntN by 1, mod 256, on each cycle with yN_valid && yN_ready, wrapping 255 to 0.
REQ-024 SHALL ignore in_data and in_sel when in_valid=0.
REQ-025 SHALL never route one word to both slots and SHALL never drop an accepted word.

Reset
REQ-026 When rst_n=0, SHALL immediately, without waiting for clk, force y0_valid=0, y1_valid=0, y0_data=0, y1_data=0, ptr=0, cnt0=0 and cnt1=0.
REQ-027 SHALL discard any in-flight words held in the slots at reset.
REQ-028 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.
REQ-029 SHALL keep in_ready purely combinational and not force it during reset, since it follows from the cleared valids.

Verification
REQ-030 Steered routing: mode=0, sel=1, data=8'hA5, y1_ready=1 -> y1_valid=1 with y1_data=A5 on the next cycle, y0_valid stays 0, and cnt1=1 after drain.
REQ-031 Stall isolation: y0 holds 8'h11 with y0_ready=0, then sel=0, data=8'h22 -> in_ready=0 and y0_data stays 11; then sel=1, data=8'h33 -> accepted, y1_data=33.
REQ-032 Back-to-back: mode=0, sel=0, y0_ready=1, words 01,02,03 on consecutive cycles -> y0_data shows 01,02,03 on consecutive cycles with in_ready held at 1, and cnt0=3.
REQ-033 Alternating: mode=1 from reset, both readies=1, words 10,20,30,40 -> y0 receives 10 and 30, y1 receives 20 and 40, regardless of in_sel.
REQ-034 Counter wrap: 256 drains on y1 -> cnt1 returns to 0 and cnt0 is unchanged.
REQ-035 Reset mid-operation: both slots valid and stalled, rst_n pulsed low between clk edges -> both valids drop at once, the counters are 0, and the first word after release routes to y0 in mode=1.

Source files
------------

// File: rtl/demux1to2_buf.sv
// -----------------------------------------------------------------------------
// demux1to2_buf
//
// Purpose:
//   Routes a stream of W-bit words from one upstream valid/ready port into
//   one of two independently buffered output slots. The destination is chosen
//   either by in_sel (mode=0) or by an internal alternating pointer (mode=1).
//   Each slot is a single-entry register stage with full throughput: a slot
//   that drains and refills in the same cycle stays valid. A stall on one slot
//   never blocks words headed for the other slot. Each slot counts its
//   completed transfers modulo 256.
//
// Ports:
//   clk       in   1   single clock, all state changes on its rising edge
//   rst_n     in   1   asynchronous active-low reset
//   in_data   in   W   upstream word
//   in_valid  in   1   in_data is presented
//   in_sel    in   1   destination when mode=0 (0 -> y0, 1 -> y1)
//   mode      in   1   0 = steered by in_sel, 1 = alternating via pointer
//   in_ready  out  1   upstream word is accepted this cycle (combinational)
//   y0_data   out  W   slot 0 data
//   y0_valid  out  1   slot 0 holds a word
//   y0_ready  in   1   slot 0 downstream takes the word
//   y1_data   out  W   slot 1 data
//   y1_valid  out  1   slot 1 holds a word
//   y1_ready  in   1   slot 1 downstream takes the word
//   cnt0      out  8   completed transfers out of slot 0 (wraps 255 -> 0)
//   cnt1      out  8   completed transfers out of slot 1 (wraps 255 -> 0)
// -----------------------------------------------------------------------------
module demux1to2_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_sel,
  input  logic         mode,
  output logic         in_ready,
  output logic [W-1:0] y0_data,
  output logic         y0_valid,
  input  logic         y0_ready,
  output logic [W-1:0] y1_data,
  output logic         y1_valid,
  input  logic         y1_ready,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
);

  // Slot 0 state
  logic [W-1:0] y0_data_q,  y0_data_d;
  logic         y0_valid_q, y0_valid_d;
  // Slot 1 state
  logic [W-1:0] y1_data_q,  y1_data_d;
  logic         y1_valid_q, y1_valid_d;
  // Alternating-mode pointer (0 -> next word to y0)
  logic         ptr_q,      ptr_d;
  // Transfer counters
  logic [7:0]   cnt0_q,     cnt0_d;
  logic [7:0]   cnt1_q,     cnt1_d;

  // Decoded handshake signals
  logic         target_s;
  logic         in_ready_s;
  logic         accept_s;
  logic         acc0_s;
  logic         acc1_s;
  logic         drain0_s;
  logic         drain1_s;

  // Next valid for a single-entry slot: a new word always wins over a drain,
  // which is what keeps the slot full when it drains and refills together.
  function automatic logic slot_valid_next(input logic valid_q,
                                           input logic ready,
                                           input logic load);
    logic nxt;
    if (load) begin
      nxt = 1'b1;
    end else if (valid_q && ready) begin
      nxt = 1'b0;
    end else begin
      nxt = valid_q;
    end
    return nxt;
  endfunction

  // Target selection and upstream ready. in_ready looks only at the target
  // slot, never at in_valid, so the other slot's stall cannot block it.
  always_comb begin
    target_s   = 1'b0;
    in_ready_s = 1'b0;
    if (mode) begin
      target_s = ptr_q;
    end else begin
      target_s = in_sel;
    end
    case (target_s)
      1'b0:    in_ready_s = !y0_valid_q || y0_ready;
      1'b1:    in_ready_s = !y1_valid_q || y1_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Accept and per-slot load/drain strobes. A word goes to exactly one slot.
  always_comb begin
    accept_s = in_valid && in_ready_s;
    acc0_s   = accept_s && (target_s == 1'b0);
    acc1_s   = accept_s && (target_s == 1'b1);
    drain0_s = y0_valid_q && y0_ready;
    drain1_s = y1_valid_q && y1_ready;
  end

  // Slot 0 next state: data only changes on a load, so it holds during stalls.
  always_comb begin
    y0_valid_d = slot_valid_next(y0_valid_q, y0_ready, acc0_s);
    if (acc0_s) begin
      y0_data_d = in_data;
    end else begin
      y0_data_d = y0_data_q;
    end
  end

  // Slot 1 next state
  always_comb begin
    y1_valid_d = slot_valid_next(y1_valid_q, y1_ready, acc1_s);
    if (acc1_s) begin
      y1_data_d = in_data;
    end else begin
      y1_data_d = y1_data_q;
    end
  end

  // Pointer toggles only on accepts made in alternating mode; held otherwise,
  // so a mode switch affects the very next accept.
  always_comb begin
    if (accept_s && mode) begin
      ptr_d = ~ptr_q;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Transfer counters, naturally modulo 256
  always_comb begin
    if (drain0_s) begin
      cnt0_d = cnt0_q + 8'd1;
    end else begin
      cnt0_d = cnt0_q;
    end
    if (drain1_s) begin
      cnt1_d = cnt1_q + 8'd1;
    end else begin
      cnt1_d = cnt1_q;
    end
  end

  // State registers; reset clears both slots, discarding any held words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_data_q  <= {W{1'b0}};
      y0_valid_q <= 1'b0;
      y1_data_q  <= {W{1'b0}};
      y1_valid_q <= 1'b0;
      ptr_q      <= 1'b0;
      cnt0_q     <= 8'd0;
      cnt1_q     <= 8'd0;
    end else begin
      y0_data_q  <= y0_data_d;
      y0_valid_q <= y0_valid_d;
      y1_data_q  <= y1_data_d;
      y1_valid_q <= y1_valid_d;
      ptr_q      <= ptr_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  // Output drive: everything registered except in_ready, which follows the
  // cleared valids during reset without being forced.
  assign in_ready = in_ready_s;
  assign y0_data  = y0_data_q;
  assign y0_valid = y0_valid_q;
  assign y1_data  = y1_data_q;
  assign y1_valid = y1_valid_q;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_demux1to2_buf.sv
// -----------------------------------------------------------------------------
// tb_demux1to2_buf
//
// Directed self-checking bench for demux1to2_buf. Inputs change #1 after a
// rising edge; outputs are sampled there as well, away from the edge.
// -----------------------------------------------------------------------------
module tb_demux1to2_buf;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_sel;
  logic         mode;
  logic         in_ready;
  logic [W-1:0] y0_data;
  logic         y0_valid;
  logic         y0_ready;
  logic [W-1:0] y1_data;
  logic         y1_valid;
  logic         y1_ready;
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;

  int n_checks;
  int n_pass;

  demux1to2_buf #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .mode     (mode),
    .in_ready (in_ready),
    .y0_data  (y0_data),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y1_data  (y1_data),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  // Clock generation, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse between edges
  task automatic pulse_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    rst_n    = 1'b1;
  endtask

  logic [7:0] words [4];
  logic       sels  [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    mode     = 1'b0;
    y0_ready = 1'b0;
    y1_ready = 1'b0;

    // Reset state
    #12;
    check("rst_y0_valid", 32'(y0_valid), 32'd0);
    check("rst_y1_valid", 32'(y1_valid), 32'd0);
    check("rst_y0_data",  32'(y0_data),  32'd0);
    check("rst_y1_data",  32'(y1_data),  32'd0);
    check("rst_cnt0",     32'(cnt0),     32'd0);
    check("rst_cnt1",     32'(cnt1),     32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Steered routing to y1
    mode = 1'b0; in_sel = 1'b1; in_data = 8'hA5; in_valid = 1'b1; y1_ready = 1'b1;
    tick();
    check("steer_y1_valid", 32'(y1_valid), 32'd1);
    check("steer_y1_data",  32'(y1_data),  32'hA5);
    check("steer_y0_valid", 32'(y0_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    check("steer_y1_drained", 32'(y1_valid), 32'd0);
    check("steer_cnt1",       32'(cnt1),     32'd1);

    // Stall isolation
    y0_ready = 1'b0; y1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
    tick();
    check("stall_y0_data_11", 32'(y0_data), 32'h11);
    in_data = 8'h22;
    #1;
    check("stall_in_ready_0", 32'(in_ready), 32'd0);
    tick();
    check("stall_y0_hold", 32'(y0_data), 32'h11);
    check("stall_y0_valid", 32'(y0_valid), 32'd1);
    in_sel = 1'b1; in_data = 8'h33;
    #1;
    check("stall_in_ready_y1", 32'(in_ready), 32'd1);
    tick();
    check("stall_y1_data", 32'(y1_data), 32'h33);
    check("stall_y1_valid", 32'(y1_valid), 32'd1);
    check("stall_y0_still", 32'(y0_data), 32'h11);
    in_valid = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;
    tick();
    check("stall_cnt0", 32'(cnt0), 32'd1);
    check("stall_cnt1", 32'(cnt1), 32'd2);

    // Back-to-back on y0
    pulse_reset();
    mode = 1'b0; in_sel = 1'b0; y0_ready = 1'b1; y1_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      #1;
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("b2b_y0_data",  32'(y0_data),  32'(i));
      check("b2b_y0_valid", 32'(y0_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_cnt0",     32'(cnt0),     32'd3);
    check("b2b_cnt1",     32'(cnt1),     32'd0);
    check("b2b_y0_empty", 32'(y0_valid), 32'd0);

    // Alternating mode, in_sel deliberately contrary
    pulse_reset();
    mode = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1;
    words[0] = 8'h10; words[1] = 8'h20; words[2] = 8'h30; words[3] = 8'h40;
    sels[0]  = 1'b1;  sels[1]  = 1'b0;  sels[2]  = 1'b1;  sels[3]  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data  = words[i];
      in_sel   = sels[i];
      in_valid = 1'b1;
      tick();
      if ((i % 2) == 0) begin
        check("alt_y0_data",  32'(y0_data),  32'(words[i]));
        check("alt_y0_valid", 32'(y0_valid), 32'd1);
        check("alt_y1_idle",  32'(y1_valid), 32'd0);
      end else begin
        check("alt_y1_data",  32'(y1_data),  32'(words[i]));
        check("alt_y1_valid", 32'(y1_valid), 32'd1);
        check("alt_y0_idle",  32'(y0_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    tick();
    check("alt_cnt0", 32'(cnt0), 32'd2);
    check("alt_cnt1", 32'(cnt1), 32'd2);

    // Counter wrap on y1
    pulse_reset();
    mode = 1'b0; in_sel = 1'b1; y0_ready = 1'b0; y1_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      tick();
    end
    check("wrap_cnt1_255", 32'(cnt1),    32'd255);
    check("wrap_y1_last",  32'(y1_data), 32'hFF);
    in_valid = 1'b0;
    tick();
    check("wrap_cnt1_0",   32'(cnt1),     32'd0);
    check("wrap_cnt0",     32'(cnt0),     32'd0);
    check("wrap_y1_empty", 32'(y1_valid), 32'd0);

    // Reset mid-operation with ptr left at 1
    pulse_reset();
    mode = 1'b1; y0_ready = 1'b1; y1_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA1; in_sel = 1'b0;
    tick();
    in_data = 8'hB2;
    tick();
    in_data = 8'hC3; y0_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("mid_pre_cnt0",    32'(cnt0),     32'd1);
    check("mid_pre_y0_data", 32'(y0_data),  32'hC3);
    check("mid_pre_y0",      32'(y0_valid), 32'd1);
    check("mid_pre_y1",      32'(y1_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_y0_valid", 32'(y0_valid), 32'd0);
    check("mid_rst_y1_valid", 32'(y1_valid), 32'd0);
    check("mid_rst_y0_data",  32'(y0_data),  32'd0);
    check("mid_rst_y1_data",  32'(y1_data),  32'd0);
    check("mid_rst_cnt0",     32'(cnt0),     32'd0);
    check("mid_rst_cnt1",     32'(cnt1),     32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    mode = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hD4; in_sel = 1'b1;
    tick();
    check("mid_first_y0_valid", 32'(y0_valid), 32'd1);
    check("mid_first_y0_data",  32'(y0_data),  32'hD4);
    check("mid_first_y1_valid", 32'(y1_valid), 32'd0);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
